// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit product.
// One Booth step per clock. Start is accepted in IDLE. The result appears
// 32 steps later, together with a one-cycle StopMult pulse.
// Optional feature: define MULT_OVERFLOW_FLAG_EN to add the MultO output. MultO
// is set when the product does not fit in 32-bit signed.
module booth_mult (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StartMult,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        StopMult,
  output logic        MultBusy
`ifdef MULT_OVERFLOW_FLAG_EN
  ,
  output logic        MultO
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multState_e;

  multState_e  state;
  logic [32:0] multiplicand;  // M, A sign-extended to 33 bits
  logic [32:0] acc;           // 33-bit accumulator, so -(-2^31) cannot overflow
  logic [31:0] q;             // multiplier, shifts out as the low product word
  logic        qPrev;         // Q-1 bit
  logic [4:0]  stepCount;     // steps already completed in RUN

  logic [32:0] addSum;
  logic [32:0] nextAcc;
  logic [31:0] nextQ;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of {acc,Q,Q-1}
  always_comb begin
    // NOTE: each output gets its default before the case. Every path then assigns it, so no latch is inferred.
    addSum = acc;
    unique case ({q[0], qPrev})
      2'b01:   addSum = acc + multiplicand;
      2'b10:   addSum = acc - multiplicand;
      default: addSum = acc;
    endcase
    nextAcc = {addSum[32], addSum[32:1]};
    nextQ   = {addSum[0], q[31:1]};
  end

`ifdef MULT_OVERFLOW_FLAG_EN
  logic nextOvf;

  // The product overflows 32 bits when the high word is not pure sign extension of the low word
  always_comb begin
    nextOvf = (nextAcc[31:0] != {32{nextQ[31]}});
  end
`endif

  // Control FSM and datapath registers, with registered status and result outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      multiplicand <= '0;
      acc          <= '0;
      q            <= '0;
      qPrev        <= 1'b0;
      stepCount    <= '0;
      Hi           <= '0;
      Lo           <= '0;
      StopMult     <= 1'b0;
      MultBusy     <= 1'b0;
`ifdef MULT_OVERFLOW_FLAG_EN
      MultO        <= 1'b0;
`endif
    end else begin
      // NOTE: registers use non-blocking assignments. Every right-hand side then reads the pre-edge value.
      unique case (state)
        IDLE: begin
          if (StartMult) begin
            multiplicand <= {A[31], A};
            q            <= B;
            qPrev        <= 1'b0;
            acc          <= '0;
            stepCount    <= '0;
            MultBusy     <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          acc       <= nextAcc;
          q         <= nextQ;
          qPrev     <= q[0];
          stepCount <= stepCount + 5'd1;
          if (stepCount == 5'd31) begin
            Hi       <= nextAcc[31:0];
            Lo       <= nextQ;
            StopMult <= 1'b1;
`ifdef MULT_OVERFLOW_FLAG_EN
            MultO    <= nextOvf;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          StopMult <= 1'b0;
          MultBusy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed and random checks of booth_mult against a plain
// 64-bit signed multiplication model.
module tb_booth_mult;

  logic        Clk;
  logic        Reset;
  logic        StartMult;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        StopMult;
  logic        MultBusy;
`ifdef MULT_OVERFLOW_FLAG_EN
  logic        MultO;
`endif

  int          testsRun  = 0;
  int          failCount = 0;
  logic [63:0] prevProd  = '0;

  booth_mult dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .StartMult (StartMult),
    .A         (A),
    .B         (B),
    .Hi        (Hi),
    .Lo        (Lo),
    .StopMult  (StopMult),
    .MultBusy  (MultBusy)
`ifdef MULT_OVERFLOW_FLAG_EN
    ,
    .MultO     (MultO)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact signed product computed with plain 64-bit arithmetic
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Run one multiplication; optionally keep StartMult high and change operands at edge 5
  task automatic runMult(input logic [31:0] a, input logic [31:0] b,
                         input bit holdStart, input bit changeOps);
    logic [63:0] expProd;
    int          stops;
    int          stopEdge;
    expProd  = refProduct(a, b);
    stops    = 0;
    stopEdge = 0;
    @(negedge Clk);
    A = a;
    B = b;
    StartMult = 1'b1;
    @(posedge Clk);
    #1;
    check("busy_after_start", 64'(MultBusy), 64'd1);
    if (!holdStart) StartMult = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge Clk);
      #1;
      if (StopMult === 1'b1) begin
        stops++;
        if (stopEdge == 0) stopEdge = e;
      end
      if (e == 5 && changeOps) begin
        A = $urandom;
        B = $urandom;
      end
      if (e == 16) check("result_hold_in_run", {Hi, Lo}, prevProd);
      if (e == 32) begin
        check("product", {Hi, Lo}, expProd);
        check("busy_in_done", 64'(MultBusy), 64'd1);
`ifdef MULT_OVERFLOW_FLAG_EN
        check("overflow", 64'(MultO), 64'(expProd[63:32] != {32{expProd[31]}}));
`endif
      end
    end
    check("stop_edge", 64'(stopEdge), 64'd32);
    check("stop_count", 64'(stops), 64'd1);
    check("idle_after_done", 64'(MultBusy), 64'd0);
    prevProd = expProd;
  endtask

  initial begin
    int stops;
    Reset     = 1'b1;
    StartMult = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_hilo", {Hi, Lo}, 64'd0);
    check("reset_stop", 64'(StopMult), 64'd0);
    check("reset_busy", 64'(MultBusy), 64'd0);
`ifdef MULT_OVERFLOW_FLAG_EN
    check("reset_multo", 64'(MultO), 64'd0);
`endif
    Reset = 1'b0;

    // Directed products, including signed cases and the most negative operand
    runMult(32'd3, 32'd5, 1'b0, 1'b0);
    check("basic_lo", 64'(Lo), 64'h0000_000F);
    runMult(32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    check("neg7x3", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("m1xm1", {Hi, Lo}, 64'h0000_0000_0000_0001);
    runMult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    check("minxmin", {Hi, Lo}, 64'h4000_0000_0000_0000);
    runMult(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    runMult(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // StartMult held across the whole run with operands changing; restart right after DONE
    runMult(32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b1);
    runMult(32'hFFFF_0001, 32'h0000_7FFF, 1'b0, 1'b0);

    // Random operands, with some small multipliers mixed in
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      runMult(ra, rb, 1'b0, 1'b0);
    end

    // Reset at RUN edge 10 aborts the operation without a completion pulse
    @(negedge Clk);
    A = 32'h0BAD_F00D;
    B = 32'h1357_9BDF;
    StartMult = 1'b1;
    @(posedge Clk);
    #1;
    StartMult = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_hilo", {Hi, Lo}, 64'd0);
    check("abort_busy", 64'(MultBusy), 64'd0);
    check("abort_stop", 64'(StopMult), 64'd0);
`ifdef MULT_OVERFLOW_FLAG_EN
    check("abort_multo", 64'(MultO), 64'd0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    prevProd = '0;
    stops = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge Clk);
      #1;
      if (StopMult === 1'b1) stops++;
    end
    check("no_stop_after_abort", 64'(stops), 64'd0);
    runMult(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    check("post_reset_product", {Hi, Lo}, 64'h0000_0001_0000_0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port Clk, input, 1 bit: clock; all state updates on rising edge.
REQ-003 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port StartMult, input, 1 bit: start request; sampled only in IDLE.
REQ-005 Port A, input, 32 bits: signed multiplicand; captured on the accepted start edge.
REQ-006 Port B, input, 32 bits: signed multiplier; captured on the accepted start edge.
REQ-007 Port Hi, output, 32 bits: upper product word; feeds the High register mux.
REQ-008 Port Lo, output, 32 bits: lower product word; feeds the Low register mux.
REQ-009 Port StopMult, output, 1 bit: completion pulse, high for exactly one cycle.
REQ-010 Port MultBusy, output, 1 bit: high while in RUN or DONE.
REQ-011 Port MultO, output, 1 bit: product overflow flag; present only when MULT_OVERFLOW_FLAG_EN is defined.

Function
REQ-012 The block SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with StartMult=1 at a rising edge, the block SHALL do all of the following on that edge: load M=A sign-extended to 33 bits, load Q=B, clear Q-1 to 0, clear the 33-bit accumulator, clear the step counter, and enter RUN.
REQ-014 In RUN, each edge SHALL perform one radix-2 Booth step on {Q[0],Q-1}:
- 01: accumulator += M.
- 10: accumulator -= M.
- 00 or 11: no add.
- Then arithmetic shift right of {accumulator,Q,Q-1} by one bit.
- Then counter += 1.
REQ-015 Arithmetic SHALL be 33-bit two's complement so that A=0x80000000 produces no internal overflow.
REQ-016 After the 32nd RUN edge, the block SHALL be in DONE, with Hi=accumulator[31:0], Lo=Q, and StopMult=1.
REQ-017 Latency: start accepted at edge 0 -> StopMult high during the cycle after edge 32 -> back to IDLE at edge 33.
REQ-018 Hi and Lo SHALL change only on the edge entering DONE, and hold their value until the next completion or reset.
REQ-019 StartMult in RUN or DONE SHALL be ignored, with no restart and no operand recapture.
REQ-020 StartMult=1 in the IDLE cycle immediately after DONE SHALL start a new operation.
REQ-021 A and B changing after the accepted start edge SHALL NOT affect the result.
REQ-022 The result SHALL equal the exact signed 64-bit product A*B for all 2^64 operand pairs.

Reset
REQ-023 While Reset=1 the block SHALL be in IDLE, with Hi=0, Lo=0, StopMult=0, MultBusy=0, MultO=0 (when present), and all internal registers at 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation immediately, with no StopMult pulse and Hi/Lo cleared to 0.
REQ-025 After reset is released, the first StartMult in IDLE SHALL be accepted normally.

Configuration
REQ-026 Macro MULT_OVERFLOW_FLAG_EN: when defined, the MultO port SHALL exist and SHALL be updated on the edge entering DONE. MultO=1 if and only if Hi is not all copies of Lo[31], i.e. the product does not fit in 32-bit signed. MultO SHALL hold its value with Hi/Lo.
REQ-027 Without MULT_OVERFLOW_FLAG_EN, the MultO port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Basic product: A=3, B=5, start -> StopMult one cycle after edge 32; Hi=0x00000000, Lo=0x0000000F.
REQ-029 Signed operands:
- A=-7, B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- A=-1, B=-1 -> Hi=0x00000000, Lo=0x00000001.
REQ-030 Corner case: A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000; with the macro, MultO=1.
REQ-031 Start while busy: StartMult held high across the whole operation with A,B changed at edge 5 -> result uses the original operands; exactly one StopMult per operation; restart in the cycle after DONE.
REQ-032 Mid-operation reset: Reset pulsed at RUN edge 10 -> Hi=Lo=0, MultBusy=0, no StopMult; a new start of A=0x00010000, B=0x00010000 -> Hi=0x00000001, Lo=0; MultO=1 with the macro, and the port is absent without it.
